qdr4_porta_ctrl: RTL and testbench

//  Controller-side initiator for one QDR-IV port (port A, burst-2, x36), single data rate at K.

---
 rtl/qdr4_porta_ctrl.sv | 142 ++++++++++++++
 tb/tb_qdr4_porta_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qdr4_porta_ctrl.sv
// QDR-IV port A initiator: command issue, DQ slot scheduling,
// write data launch and QVLD-qualified read capture.
module qdr4_porta_ctrl #(
  parameter int ADDR_W        = 22,
  parameter int DATA_W        = 36,
  parameter int READ_LATENCY  = 8,
  parameter int WRITE_LATENCY = 5,
  parameter int TURNAROUND    = 1
) (
  input  logic                K,
  input  logic                RST_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [2*DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0]   rsp_addr,
  output logic                err_qvld,
  output logic                LD_n,
  output logic                R_W_n,
  output logic [ADDR_W-1:0]   A,
  output logic                AP,
  output logic [2*DATA_W-1:0] DQ_o,
  output logic                DQ_oe,
  output logic [1:0]          DINV_o,
  input  logic [2*DATA_W-1:0] DQ_i,
  input  logic                QVLD
);

  localparam int BW = 2 * DATA_W;
  localparam int MD = READ_LATENCY + TURNAROUND + 1;
  localparam int RL = READ_LATENCY;
  localparam int WL = WRITE_LATENCY;

  // map[j] describes the DQ slot j+1 cycles ahead; dir 1 = read
  logic [MD-1:0] busy_q, dir_q;
  logic [MD-1:0] busy_d, dir_d;
  logic          fit, fire;
  int            tgt;

  logic [WL-1:0] wv_q;
  logic [BW-1:0] wd_q [WL];
  logic [RL-1:0] rp_q;
  logic [ADDR_W-1:0] ra_q [RL];
  logic          rd_hit;

  assign DINV_o = 2'b00;
  assign rd_hit = rp_q[RL-1];

  always_comb begin
    tgt = req_we ? WL : RL;
    fit = 1'b1;
    for (int k = 0; k < MD; k++) begin
      if (k == tgt && busy_q[k])
        fit = 1'b0;
      if (k != tgt &&
          k >= tgt - TURNAROUND &&
          k <= tgt + TURNAROUND &&
          busy_q[k] && dir_q[k] == req_we)
        fit = 1'b0;
    end
  end

  assign req_ready = RST_n & fit;
  assign fire      = req_valid & req_ready;

  always_comb begin
    busy_d = '0;
    dir_d  = '0;
    for (int k = 0; k < MD - 1; k++) begin
      busy_d[k] = busy_q[k+1];
      dir_d[k]  = dir_q[k+1];
    end
    for (int k = 0; k < MD; k++) begin
      if (fire && k == tgt - 1) begin
        busy_d[k] = 1'b1;
        dir_d[k]  = ~req_we;
      end
    end
  end

  always_ff @(posedge K) begin
    if (!RST_n) begin
      busy_q <= '0;
      dir_q  <= '0;
      wv_q   <= '0;
      rp_q   <= '0;
      for (int i = 0; i < WL; i++)
        wd_q[i] <= '0;
      for (int i = 0; i < RL; i++)
        ra_q[i] <= '0;
    end else begin
      busy_q  <= busy_d;
      dir_q   <= dir_d;
      wv_q[0] <= fire & req_we;
      wd_q[0] <= (fire & req_we) ? req_wdata : '0;
      for (int i = 1; i < WL; i++) begin
        wv_q[i] <= wv_q[i-1];
        wd_q[i] <= wd_q[i-1];
      end
      rp_q[0] <= ~LD_n & R_W_n;
      ra_q[0] <= A;
      for (int i = 1; i < RL; i++) begin
        rp_q[i] <= rp_q[i-1];
        ra_q[i] <= ra_q[i-1];
      end
    end
  end

  always_ff @(posedge K) begin
    if (!RST_n) begin
      LD_n      <= 1'b1;
      R_W_n     <= 1'b1;
      A         <= '0;
      AP        <= 1'b0;
      DQ_oe     <= 1'b0;
      DQ_o      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
      err_qvld  <= 1'b0;
    end else begin
      LD_n      <= ~fire;
      R_W_n     <= ~(fire & req_we);
      A         <= fire ? req_addr : '0;
      AP        <= fire & (^req_addr);
      DQ_oe     <= wv_q[WL-1];
      DQ_o      <= wd_q[WL-1];
      rsp_valid <= rd_hit & QVLD;
      if (rd_hit & QVLD) begin
        rsp_data <= DQ_i;
        rsp_addr <= ra_q[RL-1];
      end
      // missing or unexpected QVLD both latch the error
      if (rd_hit ^ QVLD)
        err_qvld <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qdr4_porta_ctrl.sv
// Bench for qdr4_porta_ctrl: scripted and random traffic against
// an absolute-cycle slot/response model and a small device model.
module tb_qdr4_porta_ctrl;

  localparam int AW  = 22;
  localparam int DW  = 36;
  localparam int BW  = 72;
  localparam int RL  = 8;
  localparam int WL  = 5;
  localparam int TA  = 1;
  localparam int BIG = 1 << 30;

  logic          K = 1'b0;
  logic          RST_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [BW-1:0] req_wdata = '0;
  logic [BW-1:0] DQ_i = '0;
  logic          QVLD = 1'b0;
  logic          req_ready, rsp_valid, err_qvld;
  logic [BW-1:0] rsp_data, DQ_o;
  logic [AW-1:0] rsp_addr, A;
  logic          LD_n, R_W_n, AP, DQ_oe;
  logic [1:0]    DINV_o;

  qdr4_porta_ctrl #(
    .ADDR_W(AW), .DATA_W(DW),
    .READ_LATENCY(RL), .WRITE_LATENCY(WL),
    .TURNAROUND(TA)
  ) dut (
    .K(K), .RST_n(RST_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .err_qvld(err_qvld),
    .LD_n(LD_n), .R_W_n(R_W_n), .A(A), .AP(AP),
    .DQ_o(DQ_o), .DQ_oe(DQ_oe), .DINV_o(DINV_o),
    .DQ_i(DQ_i), .QVLD(QVLD)
  );

  always #5 K = ~K;

  int ecnt = 0;
  always @(posedge K) ecnt <= ecnt + 1;

  typedef struct packed {
    logic v; logic we; logic [AW-1:0] addr;
    logic [BW-1:0] data; logic drop; logic spur; logic rst;
  } req_t;
  typedef struct packed { logic we; logic [AW-1:0] addr; } cmd_t;
  typedef struct packed { logic [AW-1:0] addr; logic drop; } rd_t;
  typedef struct packed { logic [AW-1:0] addr; logic [BW-1:0] data; } dat_t;

  req_t q[$];
  bit            slot_rd [int];
  cmd_t          exp_cmd [int];
  dat_t          exp_wr  [int];
  rd_t           drv     [int];
  dat_t          exp_rsp [int];
  logic [AW-1:0] dev_wq  [int];
  logic [BW-1:0] dev_mem [logic [AW-1:0]];
  logic [BW-1:0] ref_mem [logic [AW-1:0]];

  int nchk = 0;
  int nerr = 0;
  int err_at = BIG;
  int last_oe = -10;
  int last_rd = -10;
  bit post_rst = 1'b0;

  task automatic chk(input string tag,
                     input logic [BW-1:0] obs,
                     input logic [BW-1:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s cycle %0d: got %h want %h",
               tag, ecnt, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] dflt(input logic [AW-1:0] a);
    return {14'h2a5, a, 14'h1c3, a};
  endfunction

  function automatic logic [BW-1:0] rnd72();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[BW-1:0];
  endfunction

  function automatic logic [BW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [BW-1:0] dev_rd(input logic [AW-1:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : dflt(a);
  endfunction

  // a request fits if its DQ slot is free and no opposite-direction
  // slot sits within TA slots of it
  function automatic bit slot_ok(input logic we, input int s);
    if (slot_rd.exists(s)) return 1'b0;
    for (int d = 1; d <= TA; d++) begin
      if (slot_rd.exists(s - d) && slot_rd[s - d] == we) return 1'b0;
      if (slot_rd.exists(s + d) && slot_rd[s + d] == we) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic push(input logic v, input logic we,
                      input logic [AW-1:0] a, input logic [BW-1:0] d,
                      input logic drop, input logic spur,
                      input logic rst);
    req_t r;
    r.v = v; r.we = we; r.addr = a; r.data = d;
    r.drop = drop; r.spur = spur; r.rst = rst;
    q.push_back(r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(0, 0, '0, '0, 0, 0, 0);
  endtask

  task automatic observe(input int k);
    logic [BW-1:0] wd;
    if (exp_cmd.exists(k)) begin
      chk("ld_n", BW'(LD_n), BW'(1'b0));
      chk("r_w_n", BW'(R_W_n), BW'(!exp_cmd[k].we));
      chk("a", BW'(A), BW'(exp_cmd[k].addr));
      chk("ap", BW'(AP), BW'(^exp_cmd[k].addr));
      exp_cmd.delete(k);
    end else begin
      chk("ld_n_idle", BW'(LD_n), BW'(1'b1));
    end
    if (post_rst) begin
      chk("rst_a", BW'(A), '0);
      chk("rst_ap", BW'(AP), '0);
      chk("rst_r_w_n", BW'(R_W_n), BW'(1'b1));
      chk("rst_rsp_data", rsp_data, '0);
      chk("rst_rsp_addr", BW'(rsp_addr), '0);
      post_rst = 1'b0;
    end
    if (!LD_n && !R_W_n) dev_wq[k + WL] = A;
    wd = exp_wr.exists(k) ? exp_wr[k].data : '0;
    chk("dq_oe", BW'(DQ_oe), BW'(exp_wr.exists(k)));
    chk("dq_o", DQ_o, wd);
    if (exp_wr.exists(k)) begin
      ref_mem[exp_wr[k].addr] = exp_wr[k].data;
      exp_wr.delete(k);
    end
    if (DQ_oe) begin
      chk("turnaround_wr", BW'(last_rd >= k - TA), '0);
      last_oe = k;
      if (dev_wq.exists(k)) dev_mem[dev_wq[k]] = DQ_o;
    end
    if (exp_rsp.exists(k)) begin
      chk("rsp_valid", BW'(rsp_valid), BW'(1'b1));
      chk("rsp_data", rsp_data, exp_rsp[k].data);
      chk("rsp_addr", BW'(rsp_addr), BW'(exp_rsp[k].addr));
      exp_rsp.delete(k);
    end else begin
      chk("rsp_valid_idle", BW'(rsp_valid), '0);
    end
    chk("err_qvld", BW'(err_qvld), BW'(k >= err_at));
    chk("dinv", BW'(DINV_o), '0);
  endtask

  task automatic drive_dev(input int k, input bit spur);
    dat_t r;
    if (drv.exists(k)) begin
      chk("turnaround_rd", BW'(last_oe >= k - TA), '0);
      last_rd = k;
      if (drv[k].drop) begin
        QVLD = 1'b0;
        DQ_i = rnd72();
        if (k + 1 < err_at) err_at = k + 1;
      end else begin
        QVLD = 1'b1;
        DQ_i = dev_rd(drv[k].addr);
        r.addr = drv[k].addr;
        r.data = ref_rd(drv[k].addr);
        exp_rsp[k + 1] = r;
      end
      drv.delete(k);
    end else if (spur) begin
      QVLD = 1'b1;
      DQ_i = rnd72();
      if (k + 1 < err_at) err_at = k + 1;
    end else begin
      QVLD = 1'b0;
      DQ_i = rnd72();
    end
  endtask

  task automatic clear_model();
    slot_rd.delete(); exp_cmd.delete(); exp_wr.delete();
    drv.delete(); exp_rsp.delete(); dev_wq.delete();
    err_at = BIG;
    last_oe = -10;
    last_rd = -10;
    post_rst = 1'b1;
  endtask

  task automatic accept(input int e, input req_t r);
    cmd_t c;
    dat_t w;
    rd_t  d;
    c.we = r.we; c.addr = r.addr;
    exp_cmd[e] = c;
    if (r.we) begin
      w.addr = r.addr; w.data = r.data;
      slot_rd[e + WL] = 1'b0;
      exp_wr[e + WL] = w;
    end else begin
      d.addr = r.addr; d.drop = r.drop;
      slot_rd[e + RL] = 1'b1;
      drv[e + RL] = d;
    end
  endtask

  initial begin
    req_t cur;
    int   k;
    bit   rdy;

    push(0, 0, '0, '0, 0, 0, 1);
    push(0, 0, '0, '0, 0, 0, 1);
    idle(2);
    push(1, 1, 22'h000155, 72'h123456789ABCDEF012, 0, 0, 0);
    push(1, 0, 22'h000155, '0, 0, 0, 0);
    idle(14);
    for (int i = 0; i < 8; i++) push(1, 0, AW'(i), '0, 0, 0, 0);
    idle(14);
    push(1, 0, 22'h000020, '0, 0, 0, 0);
    idle(1);
    push(1, 1, 22'h000021, rnd72(), 0, 0, 0);
    push(1, 0, 22'h000021, '0, 0, 0, 0);
    idle(14);
    push(1, 1, 22'h000007, rnd72(), 0, 0, 0);
    push(1, 1, 22'h000003, rnd72(), 0, 0, 0);
    push(1, 0, 22'h000007, '0, 0, 0, 0);
    push(1, 0, 22'h000003, '0, 0, 0, 0);
    idle(14);
    push(1, 0, 22'h000040, '0, 1, 0, 0);
    idle(14);
    for (int i = 0; i < 3; i++) push(1, 0, AW'(8'h50 + i), '0, 0, 0, 0);
    idle(2);
    push(0, 0, '0, '0, 0, 0, 1);
    idle(3);
    push(0, 0, '0, '0, 0, 1, 0);
    idle(3);
    push(0, 0, '0, '0, 0, 0, 1);
    idle(2);
    for (int i = 0; i < 300; i++)
      push($urandom_range(0, 9) < 7, 1'($urandom()),
           AW'($urandom_range(0, 15)), rnd72(), 0, 0, 0);
    idle(16);

    while (q.size() != 0) begin
      @(negedge K);
      k = ecnt;
      if (k > 20000) begin
        nchk++;
        nerr++;
        $display("FAIL timeout cycle %0d: %0d requests left", k, q.size());
        break;
      end
      if (k >= 1) observe(k);
      cur = q[0];
      RST_n     = !cur.rst;
      req_valid = cur.v;
      req_we    = cur.we;
      req_addr  = cur.addr;
      req_wdata = cur.data;
      if (cur.rst) clear_model();
      drive_dev(k, cur.spur);
      #1;
      rdy = cur.rst ? 1'b0 :
            slot_ok(cur.we, k + 1 + (cur.we ? WL : RL));
      chk("req_ready", BW'(req_ready), BW'(rdy));
      if (cur.v && rdy) accept(k + 1, cur);
      if (!cur.v || rdy) void'(q.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
